knn_sched: RTL and testbench
============================

KNN_SCHED -- requirements
Module: knn_sched

Interface
REQ-001 The block SHALL have parameter N_TRAIN, default 1024: number of training vectors swept per classification (range 2..2^ADDR_W).
REQ-002 The block SHALL have parameter ADDR_W, default 10: training-ROM address width.
REQ-003 The block SHALL have parameter PIPE_LAT, default 4: cycles from address issue to the last sort update (ROM + ds + sigma + sort); range 1..15.
REQ-004 The block SHALL have port clk_knn, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port start_valid, input, 1 bit: a classification request is present.
REQ-007 The block SHALL have port start_ready, output, 1 bit: a request can be accepted.
REQ-008 The block SHALL have port feature_in, input, 32 bits: four 8-bit features of the request.
REQ-009 The block SHALL have port feature, output, 32 bits: latched feature held stable for the datapath.
REQ-010 The block SHALL have port address, output, ADDR_W bits: training-ROM address.
REQ-011 The block SHALL have port addr_valid, output, 1 bit: address carries a live sweep index.
REQ-012 The block SHALL have port sort_clr, output, 1 bit: clear pulse to both candidate sorters.
REQ-013 The block SHALL have port cls_in, input, 3 bits: class from the result stage.
REQ-014 The block SHALL have port result, output, 3 bits: registered classification.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have port busy, output, 1 bit: asserted in every state other than IDLE.
REQ-017 The block SHALL have port abort, input, 1 bit, present only with KNN_SCHED_ABORT_EN.

Function
REQ-018 The block SHALL implement a state machine with states IDLE, CLEAR, SWEEP, DRAIN and RESULT.
REQ-019 start_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where start_valid and start_ready are both 1.
REQ-020 On acceptance the block SHALL latch feature_in into feature and go to CLEAR; feature SHALL hold until the next acceptance.
REQ-021 CLEAR SHALL last one cycle with sort_clr=1, then go to SWEEP with address=0.
REQ-022 In SWEEP the block SHALL hold addr_valid=1 and increment address by 1 per cycle, issuing 0..N_TRAIN-1 in exactly N_TRAIN cycles.
REQ-023 After the cycle with address=N_TRAIN-1 the block SHALL go to DRAIN; address SHALL hold at N_TRAIN-1 and addr_valid=0.
REQ-024 DRAIN SHALL last exactly PIPE_LAT cycles; on its final edge the block SHALL capture cls_in into result.
REQ-025 RESULT SHALL last one cycle with done=1, then go to IDLE.
REQ-026 For an acceptance at edge t, done SHALL be 1 in the cycle t+N_TRAIN+PIPE_LAT+2, counting the cycle after edge t as t+1.
REQ-027 result SHALL hold its value until the next capture.
REQ-028 start_valid asserted while busy SHALL be ignored, with no queuing.
REQ-029 In the RESULT cycle start_ready SHALL be 0, so back-to-back requests are accepted at the earliest on the cycle after done.
REQ-030 The DRAIN counter SHALL be ceil(log2(PIPE_LAT+1)) bits wide; the address counter SHALL be ADDR_W bits and SHALL NOT wrap during a sweep.
REQ-031 sort_clr, addr_valid and done SHALL be 0 outside the states named in REQ-021, REQ-022 and REQ-025.

Reset
REQ-032 While rst=1 at a clock edge the block SHALL enter IDLE with feature=0, address=0, addr_valid=0, sort_clr=0, result=0, done=0, busy=0 and start_ready=1 from the next cycle.
REQ-033 Reset during any state SHALL abandon the classification with no done pulse; result SHALL return to 0.

Configuration
REQ-034 With KNN_SCHED_ABORT_EN defined, abort=1 in CLEAR, SWEEP or DRAIN SHALL force IDLE on the next edge with no done pulse and result unchanged.
REQ-035 With KNN_SCHED_ABORT_EN defined, abort=1 in IDLE or RESULT SHALL have no effect; abort and start_valid in the same IDLE cycle SHALL accept the request.
REQ-036 Without KNN_SCHED_ABORT_EN the abort port and its logic SHALL be absent.

Structure
REQ-037 The state encoding (enum knn_state_t), the default N_TRAIN, ADDR_W and PIPE_LAT, and the 3-bit class width SHALL be defined in shared package knn_pkg.
REQ-038 The block SHALL be a single module with no sub-modules; the ROM, ds, sigma, sort and result stages remain external.

Verification
REQ-039 With N_TRAIN=8 and PIPE_LAT=4, start at edge 0: sort_clr in cycle 1, address 0..7 in cycles 2..9, done in cycle 14, result equal to cls_in sampled at the edge ending cycle 13.
REQ-040 start_valid held high continuously: second acceptance on the edge after done; feature updates only then; mid-run start pulses ignored.
REQ-041 feature_in=32'hA1B2C3D4 at acceptance, then changed every cycle: feature stays A1B2C3D4 through done.
REQ-042 rst=1 in SWEEP at address 5: next cycle IDLE, address=0, result=0, no done pulse.
REQ-043 KNN_SCHED_ABORT_EN defined, abort in DRAIN: IDLE next cycle, no done, result keeps its previous value; abort in IDLE with start_valid: request accepted.
REQ-044 N_TRAIN=1024 with default parameters: addresses 0..1023 each issued exactly once, no wrap, done 1030 cycles after the acceptance edge.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared definitions for the k-NN classification scheduler: FSM encoding,
// default sizing and the class width.
package knn_pkg;

    localparam int unsigned N_TRAIN_DEF  = 1024;
    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned PIPE_LAT_DEF = 4;
    localparam int unsigned CLS_W        = 3;

    typedef logic [CLS_W-1:0] cls_t;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSweep,
        StDrain,
        StResult
    } knn_state_t;

endpackage

// File: rtl/knn_sched_if.sv
// Request/response and datapath-control bundle between the k-NN scheduler
// (slave) and its surrounding datapath/requester (master).
interface knn_sched_if #(
    parameter int unsigned ADDR_W = knn_pkg::ADDR_W_DEF
);
    import knn_pkg::*;

    logic              start_valid;
    logic              start_ready;
    logic [31:0]       feature_in;
    logic [31:0]       feature;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic              sort_clr;
    cls_t              cls_in;
    cls_t              result;
    logic              done;
    logic              busy;

    modport master (
        output start_valid, feature_in, cls_in,
        input  start_ready, feature, address, addr_valid, sort_clr, result, done, busy
    );

    modport slave (
        input  start_valid, feature_in, cls_in,
        output start_ready, feature, address, addr_valid, sort_clr, result, done, busy
    );

endinterface

// File: rtl/knn_sched.sv
// k-NN classification scheduler: clears the sorters, sweeps the training ROM,
// drains the pipeline and captures the class. Optional abort: KNN_SCHED_ABORT_EN.
module knn_sched
    import knn_pkg::*;
#(
    parameter int unsigned N_TRAIN  = N_TRAIN_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic       clk_knn,
    input  logic       rst,
`ifdef KNN_SCHED_ABORT_EN
    input  logic       abort,
`endif
    knn_sched_if.slave bus
);

    localparam int unsigned       CNT_W      = $clog2(PIPE_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_TRAIN - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

    knn_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       feature_q;
    cls_t              result_q;
    logic              accept;
    logic              capture;
    logic              abort_hit;

`ifdef KNN_SCHED_ABORT_EN
    assign abort_hit = abort &&
                       (state_q == StClear || state_q == StSweep || state_q == StDrain);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk_knn) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start_valid) begin
                    accept  = 1'b1;
                    state_d = StClear;
                end
            end
            StClear:  state_d = StSweep;
            StSweep: begin
                if (addr_q == LAST_ADDR) state_d = StDrain;
            end
            StDrain: begin
                if (cnt_q == DRAIN_LAST) begin
                    capture = 1'b1;
                    state_d = StResult;
                end
            end
            StResult: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Abort wins over the final drain capture so result stays untouched.
        if (abort_hit) begin
            state_d = StIdle;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk_knn) begin
        if (rst) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            feature_q <= '0;
            result_q  <= '0;
        end else begin
            if (accept) feature_q <= bus.feature_in;
            if (capture) result_q <= bus.cls_in;
            if (accept || abort_hit) begin
                addr_q <= '0;
            end else if (state_q == StSweep && addr_q != LAST_ADDR) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state_q == StSweep) begin
                cnt_q <= '0;
            end else if (state_q == StDrain) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.start_ready = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.sort_clr    = (state_q == StClear);
    assign bus.addr_valid  = (state_q == StSweep);
    assign bus.done        = (state_q == StResult);
    assign bus.address     = addr_q;
    assign bus.feature     = feature_q;
    assign bus.result      = result_q;

endmodule

// File: tb/tb_knn_sched.sv
// Directed bench for knn_sched: a short-sweep instance (N_TRAIN=8, 3-bit address)
// and a default-size instance (N_TRAIN=1024).
module tb_knn_sched;
    import knn_pkg::*;

    localparam int unsigned NA  = 8;
    localparam int unsigned AWA = 3;
    localparam int unsigned PL  = 4;
    localparam int unsigned NB  = 1024;
    localparam int unsigned AWB = 10;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    knn_sched_if #(.ADDR_W(AWA)) ia ();
    knn_sched_if #(.ADDR_W(AWB)) ib ();

`ifdef KNN_SCHED_ABORT_EN
    logic abort_a;
    logic abort_b;
`endif

    knn_sched #(.N_TRAIN(NA), .ADDR_W(AWA), .PIPE_LAT(PL)) dut_a (
        .clk_knn (clk),
        .rst     (rst),
`ifdef KNN_SCHED_ABORT_EN
        .abort   (abort_a),
`endif
        .bus     (ia)
    );

    knn_sched #(.N_TRAIN(NB), .ADDR_W(AWB), .PIPE_LAT(PL)) dut_b (
        .clk_knn (clk),
        .rst     (rst),
`ifdef KNN_SCHED_ABORT_EN
        .abort   (abort_b),
`endif
        .bus     (ib)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected {start_ready, busy, sort_clr, addr_valid, done} in cycle k after acceptance.
    function automatic logic [4:0] exp_ctl(int k, int n);
        if (k == 1) return 5'b01100;
        if (k >= 2 && k <= n + 1) return 5'b01010;
        if (k >= n + 2 && k <= n + PL + 1) return 5'b01000;
        if (k == n + PL + 2) return 5'b01001;
        return 5'b10000;
    endfunction

    function automatic int exp_addr(int k, int n);
        if (k <= 1) return 0;
        if (k <= n + 1) return k - 2;
        return n - 1;
    endfunction

    function automatic logic [4:0] ctl_a();
        return {ia.start_ready, ia.busy, ia.sort_clr, ia.addr_valid, ia.done};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        ia.start_valid = 1'b0; ia.feature_in = 32'hDEAD_BEEF; ia.cls_in = 3'd7;
        ib.start_valid = 1'b0; ib.feature_in = 32'h0;         ib.cls_in = 3'd0;
        repeat (3) tick;
        rst = 1'b0;
        checks++;
        if (ctl_a() !== 5'b10000)
            begin errors++; $display("FAIL reset_ctl got %b want 10000", ctl_a()); end
        checks++;
        if (ia.feature !== 32'h0 || ia.address !== 3'd0 || ia.result !== 3'd0)
            begin errors++; $display("FAIL reset_data got f=%h a=%0d r=%0d want 0 0 0",
                                     ia.feature, ia.address, ia.result); end
        checks++;
        if (ib.start_ready !== 1'b1 || ib.busy !== 1'b0 || ib.address !== 10'd0)
            begin errors++; $display("FAIL reset_b got rdy=%b busy=%b a=%0d want 1 0 0",
                                     ib.start_ready, ib.busy, ib.address); end
    endtask

    task automatic test_timing;
        cls_t cls13 = 3'd0;
        ia.start_valid = 1'b1; ia.feature_in = 32'h0102_0304;
        tick;
        ia.start_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (ctl_a() !== exp_ctl(k, NA))
                begin errors++; $display("FAIL timing_ctl cyc %0d got %b want %b",
                                         k, ctl_a(), exp_ctl(k, NA)); end
            checks++;
            if (ia.address !== AWA'(exp_addr(k, NA)))
                begin errors++; $display("FAIL timing_addr cyc %0d got %0d want %0d",
                                         k, ia.address, exp_addr(k, NA)); end
            checks++;
            if (ia.result !== ((k <= 13) ? 3'd0 : cls13))
                begin errors++; $display("FAIL timing_result cyc %0d got %0d want %0d",
                                         k, ia.result, (k <= 13) ? 3'd0 : cls13); end
            ia.cls_in = 3'(k + 1);
            if (k == 13) cls13 = ia.cls_in;
            ia.start_valid = (k == 5);   // mid-run pulse must be ignored
            tick;
        end
    endtask

    task automatic test_feature_hold;
        ia.cls_in = 3'd3;
        ia.start_valid = 1'b1; ia.feature_in = 32'hA1B2_C3D4;
        tick;
        ia.start_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            checks++;
            if (ia.feature !== 32'hA1B2_C3D4)
                begin errors++; $display("FAIL feature_hold cyc %0d got %h want a1b2c3d4",
                                         k, ia.feature); end
            ia.feature_in = $urandom;
            if (k == 14) begin
                checks++;
                if (ia.done !== 1'b1 || ia.result !== 3'd3)
                    begin errors++; $display("FAIL feature_done got done=%b r=%0d want 1 3",
                                             ia.done, ia.result); end
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] f0 = 32'h1111_0000;
        logic [31:0] f1 = 32'h0;
        logic [4:0]  want;
        logic        idle = 1'b0;
        ia.start_valid = 1'b1; ia.feature_in = f0;
        tick;
        for (int k = 1; k <= 17; k++) begin
            want = (k <= 15) ? exp_ctl(k, NA) : exp_ctl(k - 15, NA);
            checks++;
            if (ctl_a() !== want)
                begin errors++; $display("FAIL b2b_ctl cyc %0d got %b want %b",
                                         k, ctl_a(), want); end
            checks++;
            if (ia.feature !== ((k <= 15) ? f0 : f1))
                begin errors++; $display("FAIL b2b_feature cyc %0d got %h want %h",
                                         k, ia.feature, (k <= 15) ? f0 : f1); end
            ia.feature_in = 32'h1111_0000 + k;
            if (k == 15) f1 = ia.feature_in;
            tick;
        end
        ia.start_valid = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            tick;
            idle = ia.start_ready;
        end
        checks++;
        if (idle !== 1'b1)
            begin errors++; $display("FAIL b2b_drain got idle=%b want 1", idle); end
    endtask

    task automatic test_reset_mid;
        logic saw_done = 1'b0;
        ia.start_valid = 1'b1;
        tick;
        ia.start_valid = 1'b0;
        repeat (6) tick;
        checks++;
        if (ia.address !== 3'd5 || ia.addr_valid !== 1'b1)
            begin errors++; $display("FAIL rstmid_pre got a=%0d v=%b want 5 1",
                                     ia.address, ia.addr_valid); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (ctl_a() !== 5'b10000 || ia.address !== 3'd0 || ia.result !== 3'd0)
            begin errors++; $display("FAIL rstmid_post got c=%b a=%0d r=%0d want 10000 0 0",
                                     ctl_a(), ia.address, ia.result); end
        for (int i = 0; i < 20; i++) begin
            if (ia.done) saw_done = 1'b1;
            tick;
        end
        checks++;
        if (saw_done !== 1'b0)
            begin errors++; $display("FAIL rstmid_nodone got %b want 0", saw_done); end
    endtask

`ifdef KNN_SCHED_ABORT_EN
    task automatic test_abort;
        logic seen = 1'b0;
        ia.cls_in = 3'd5;
        ia.start_valid = 1'b1;
        tick;
        ia.start_valid = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin tick; seen = ia.done; end
        checks++;
        if (seen !== 1'b1 || ia.result !== 3'd5)
            begin errors++; $display("FAIL abort_setup got done=%b r=%0d want 1 5",
                                     seen, ia.result); end
        tick;
        ia.cls_in = 3'd2;
        ia.start_valid = 1'b1;
        tick;
        ia.start_valid = 1'b0;
        repeat (10) tick;               // cycle 11: in DRAIN
        abort_a = 1'b1;
        tick;
        checks++;
        if (ctl_a() !== 5'b10000 || ia.result !== 3'd5)
            begin errors++; $display("FAIL abort_drain got c=%b r=%0d want 10000 5",
                                     ctl_a(), ia.result); end
        ia.start_valid = 1'b1;
        tick;
        abort_a = 1'b0;
        ia.start_valid = 1'b0;
        checks++;
        if (ctl_a() !== 5'b01100)
            begin errors++; $display("FAIL abort_idle_accept got %b want 01100", ctl_a()); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin tick; seen = ia.done; end
        checks++;
        if (seen !== 1'b1 || ia.result !== 3'd2)
            begin errors++; $display("FAIL abort_rerun got done=%b r=%0d want 1 2",
                                     seen, ia.result); end
        tick;
    endtask
`endif

    task automatic test_long_sweep;
        int next_addr = 0;
        int bad       = 0;
        int done_cnt  = 0;
        int done_cyc  = -1;
        ib.start_valid = 1'b1;
        tick;
        ib.start_valid = 1'b0;
        for (int k = 1; k <= 1040; k++) begin
            if (ib.addr_valid) begin
                if (ib.address !== AWB'(next_addr)) bad++;
                next_addr++;
            end
            if (ib.done) begin done_cnt++; done_cyc = k; end
            tick;
        end
        checks++;
        if (next_addr != 1024 || bad != 0)
            begin errors++; $display("FAIL long_addr got issued=%0d bad=%0d want 1024 0",
                                     next_addr, bad); end
        checks++;
        if (done_cnt != 1 || done_cyc != 1030)
            begin errors++; $display("FAIL long_done got cnt=%0d cyc=%0d want 1 1030",
                                     done_cnt, done_cyc); end
        checks++;
        if (ib.address !== 10'd1023)
            begin errors++; $display("FAIL long_hold got %0d want 1023", ib.address); end
    endtask

    initial begin
`ifdef KNN_SCHED_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        test_reset();
        test_timing();
        test_feature_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef KNN_SCHED_ABORT_EN
        test_abort();
`endif
        test_long_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
